// File: rtl/nmc_req_sched.sv
// Shares one nmc between N_REQ requesters: round-robin write/query arbitration,
// query tagging through an in-order tag FIFO, and response routing back to the issuer.
module nmc_req_sched #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 16,
   parameter int ENTRY_W   = 64,
   parameter int FEAT_W    = 64,
   parameter int RES_W     = 32,
   parameter int MAX_OUTST = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              wr_valid,
   output logic [N_REQ-1:0]              wr_ready,
   input  logic [N_REQ*ADDR_W-1:0]       wr_addr,
   input  logic [N_REQ*ENTRY_W-1:0]      wr_entry,
   input  logic [N_REQ-1:0]              qr_valid,
   output logic [N_REQ-1:0]              qr_ready,
   input  logic [N_REQ*ADDR_W-1:0]       qr_addr,
   input  logic [N_REQ*FEAT_W-1:0]       qr_feature,
   output logic                          nwr_push,
   output logic [ADDR_W-1:0]             nwr_addr,
   output logic [ENTRY_W-1:0]            nwr_entry,
   input  logic                          nwr_full,
   output logic                          nqr_push,
   output logic [ADDR_W-1:0]             nqr_addr,
   output logic [FEAT_W-1:0]             nqr_feature,
   output logic [$clog2(N_REQ)-1:0]      nqr_id,
   input  logic                          nqr_full,
   input  logic                          nresp_valid,
   input  logic                          nresp_found,
   input  logic [RES_W-1:0]              nresp_result,
   output logic [N_REQ-1:0]              resp_valid,
   output logic                          resp_found,
   output logic [RES_W-1:0]              resp_result,
   input  logic                          drain,
   output logic                          drain_done,
   output logic [$clog2(MAX_OUTST):0]    outstanding,
   output logic                          err_orphan
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_r;
   logic [IDX_W-1:0]   wr_ptr_r;
   logic [IDX_W-1:0]   qr_ptr_r;
   logic [IDX_W-1:0]   tag_mem_r [MAX_OUTST];
   logic [PTR_W-1:0]   tag_wp_r;
   logic [PTR_W-1:0]   tag_rp_r;
   logic [CNT_W-1:0]   tag_cnt_r;
   logic [N_REQ-1:0]   resp_valid_r;
   logic               resp_found_r;
   logic [RES_W-1:0]   resp_result_r;
   logic               err_orphan_r;

   logic               wr_found_s;
   logic               qr_found_s;
   logic [IDX_W-1:0]   wr_idx_s;
   logic [IDX_W-1:0]   qr_idx_s;
   logic               wr_gnt_s;
   logic               qr_gnt_s;
   logic               tag_pop_s;
   logic               orphan_s;
   logic [IDX_W-1:0]   pop_tag_s;

   // First asserted request at or after ptr, wrapping modulo N_REQ; returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] vld, input logic [IDX_W-1:0] ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               j;
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         j     = int'(ptr) + k;
         j     = (j >= N_REQ) ? j - N_REQ : j;
         idx   = (!found && vld[j]) ? IDX_W'(j) : idx;
         found = found | vld[j];
      end
      return {found, idx};
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
   endfunction

   // Arbitration, grant qualification and zero-latency payload muxing.
   always_comb begin
      {wr_found_s, wr_idx_s} = rr_pick(wr_valid, wr_ptr_r);
      {qr_found_s, qr_idx_s} = rr_pick(qr_valid, qr_ptr_r);
      wr_gnt_s  = wr_found_s && (state_r == ST_RUN) && !nwr_full;
      // Tag space is judged on the current count only; a same-cycle pop does not free a slot.
      qr_gnt_s  = qr_found_s && (state_r == ST_RUN) && !nqr_full && (tag_cnt_r != CNT_W'(MAX_OUTST));
      tag_pop_s = nresp_valid && (tag_cnt_r != {CNT_W{1'b0}});
      orphan_s  = nresp_valid && (tag_cnt_r == {CNT_W{1'b0}});
      pop_tag_s = tag_mem_r[tag_rp_r];

      wr_ready    = wr_gnt_s ? (N_REQ'(1'b1) << wr_idx_s) : {N_REQ{1'b0}};
      nwr_push    = wr_gnt_s;
      nwr_addr    = wr_gnt_s ? wr_addr[int'(wr_idx_s)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
      nwr_entry   = wr_gnt_s ? wr_entry[int'(wr_idx_s)*ENTRY_W +: ENTRY_W] : {ENTRY_W{1'b0}};
      qr_ready    = qr_gnt_s ? (N_REQ'(1'b1) << qr_idx_s) : {N_REQ{1'b0}};
      nqr_push    = qr_gnt_s;
      nqr_addr    = qr_gnt_s ? qr_addr[int'(qr_idx_s)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
      nqr_feature = qr_gnt_s ? qr_feature[int'(qr_idx_s)*FEAT_W +: FEAT_W] : {FEAT_W{1'b0}};
      nqr_id      = qr_gnt_s ? qr_idx_s : {IDX_W{1'b0}};
   end

   // Round-robin pointers and the requester-tag FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r  <= {IDX_W{1'b0}};
         qr_ptr_r  <= {IDX_W{1'b0}};
         tag_wp_r  <= {PTR_W{1'b0}};
         tag_rp_r  <= {PTR_W{1'b0}};
         tag_cnt_r <= {CNT_W{1'b0}};
         for (int i = 0; i < MAX_OUTST; i++) begin
            tag_mem_r[i] <= {IDX_W{1'b0}};
         end
      end else begin
         if (wr_gnt_s) begin
            wr_ptr_r <= next_ptr(wr_idx_s);
         end
         if (qr_gnt_s) begin
            qr_ptr_r            <= next_ptr(qr_idx_s);
            tag_mem_r[tag_wp_r] <= qr_idx_s;
            tag_wp_r            <= tag_wp_r + PTR_W'(1);
         end
         if (tag_pop_s) begin
            tag_rp_r <= tag_rp_r + PTR_W'(1);
         end
         case ({qr_gnt_s, tag_pop_s})
            2'b10:   tag_cnt_r <= tag_cnt_r + CNT_W'(1);
            2'b01:   tag_cnt_r <= tag_cnt_r - CNT_W'(1);
            default: tag_cnt_r <= tag_cnt_r;
         endcase
      end
   end

   // Registered response strobe/payload and the sticky orphan flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid_r  <= {N_REQ{1'b0}};
         resp_found_r  <= 1'b0;
         resp_result_r <= {RES_W{1'b0}};
         err_orphan_r  <= 1'b0;
      end else begin
         resp_valid_r <= tag_pop_s ? (N_REQ'(1'b1) << pop_tag_s) : {N_REQ{1'b0}};
         if (tag_pop_s) begin
            resp_found_r  <= nresp_found;
            resp_result_r <= nresp_result;
         end
         if (orphan_s) begin
            err_orphan_r <= 1'b1;
         end
      end
   end

   // Drain FSM: RUN -> DRAIN -> DONE -> RUN, skipping DRAIN when nothing is outstanding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (drain) begin
                  state_r <= (tag_cnt_r == {CNT_W{1'b0}}) ? ST_DONE : ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!drain) begin
                  state_r <= ST_RUN;
               end else if (tag_cnt_r == {CNT_W{1'b0}}) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!drain) begin
                  state_r <= ST_RUN;
               end
            end
            default: state_r <= ST_RUN;
         endcase
      end
   end

   assign resp_valid  = resp_valid_r;
   assign resp_found  = resp_found_r;
   assign resp_result = resp_result_r;
   assign err_orphan  = err_orphan_r;
   assign drain_done  = (state_r == ST_DONE);
   assign outstanding = tag_cnt_r;

endmodule

// File: tb/tb_nmc_req_sched.sv
// Directed self-checking bench for nmc_req_sched with default parameters (N_REQ=4, MAX_OUTST=8).
module tb_nmc_req_sched;

   logic          clk;
   logic          rst;
   logic [3:0]    wr_valid;
   logic [3:0]    wr_ready;
   logic [63:0]   wr_addr;
   logic [255:0]  wr_entry;
   logic [3:0]    qr_valid;
   logic [3:0]    qr_ready;
   logic [63:0]   qr_addr;
   logic [255:0]  qr_feature;
   logic          nwr_push;
   logic [15:0]   nwr_addr;
   logic [63:0]   nwr_entry;
   logic          nwr_full;
   logic          nqr_push;
   logic [15:0]   nqr_addr;
   logic [63:0]   nqr_feature;
   logic [1:0]    nqr_id;
   logic          nqr_full;
   logic          nresp_valid;
   logic          nresp_found;
   logic [31:0]   nresp_result;
   logic [3:0]    resp_valid;
   logic          resp_found;
   logic [31:0]   resp_result;
   logic          drain;
   logic          drain_done;
   logic [3:0]    outstanding;
   logic          err_orphan;

   int errors = 0;
   int checks = 0;

   nmc_req_sched dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_entry(wr_entry),
      .qr_valid(qr_valid), .qr_ready(qr_ready), .qr_addr(qr_addr), .qr_feature(qr_feature),
      .nwr_push(nwr_push), .nwr_addr(nwr_addr), .nwr_entry(nwr_entry), .nwr_full(nwr_full),
      .nqr_push(nqr_push), .nqr_addr(nqr_addr), .nqr_feature(nqr_feature), .nqr_id(nqr_id),
      .nqr_full(nqr_full),
      .nresp_valid(nresp_valid), .nresp_found(nresp_found), .nresp_result(nresp_result),
      .resp_valid(resp_valid), .resp_found(resp_found), .resp_result(resp_result),
      .drain(drain), .drain_done(drain_done), .outstanding(outstanding), .err_orphan(err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] exp_rdy;
      rst = 1'b0;
      wr_valid = 4'h0; qr_valid = 4'h0; nwr_full = 1'b0; nqr_full = 1'b0;
      nresp_valid = 1'b0; nresp_found = 1'b0; nresp_result = 32'h0; drain = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_addr[i*16 +: 16]    = 16'h1000 + 16'(i);
         wr_entry[i*64 +: 64]   = 64'hE000 + 64'(i);
         qr_addr[i*16 +: 16]    = 16'h2000 + 16'(i);
         qr_feature[i*64 +: 64] = 64'hF000 + 64'(i);
      end
      #2;
      checks++; if (wr_ready !== 4'h0 || nwr_push !== 1'b0) begin errors++; $display("FAIL rst_wr got=%h/%b exp=0/0", wr_ready, nwr_push); end
      checks++; if (qr_ready !== 4'h0 || nqr_push !== 1'b0) begin errors++; $display("FAIL rst_qr got=%h/%b exp=0/0", qr_ready, nqr_push); end
      checks++; if (resp_valid !== 4'h0 || resp_found !== 1'b0 || resp_result !== 32'h0) begin errors++; $display("FAIL rst_resp got=%h/%b/%h exp=0", resp_valid, resp_found, resp_result); end
      checks++; if (outstanding !== 4'd0 || err_orphan !== 1'b0 || drain_done !== 1'b0) begin errors++; $display("FAIL rst_status got=%0d/%b/%b exp=0/0/0", outstanding, err_orphan, drain_done); end
      tick(); tick();
      rst = 1'b1;
      wr_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'h1 << (k % 4);
         checks++; if (wr_ready !== exp_rdy || nwr_push !== 1'b1) begin errors++; $display("FAIL rr_grant%0d got=%h exp=%h", k, wr_ready, exp_rdy); end
         checks++; if (nwr_addr !== 16'h1000 + 16'(k % 4) || nwr_entry !== 64'hE000 + 64'(k % 4)) begin errors++; $display("FAIL rr_payload%0d got=%h/%h", k, nwr_addr, nwr_entry); end
         tick();
      end
      wr_valid = 4'h0;
   endtask

   task automatic test_backpressure();
      wr_valid = 4'b0100; nwr_full = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (wr_ready !== 4'h0 || nwr_push !== 1'b0) begin errors++; $display("FAIL full_block%0d got=%h/%b exp=0/0", k, wr_ready, nwr_push); end
         tick();
      end
      nwr_full = 1'b0;
      #1;
      checks++; if (wr_ready !== 4'b0100 || nwr_push !== 1'b1 || nwr_addr !== 16'h1002) begin errors++; $display("FAIL full_release got=%h/%b/%h exp=4/1/1002", wr_ready, nwr_push, nwr_addr); end
      tick();
      wr_valid = 4'h0;
   endtask

   task automatic test_tag_limit();
      qr_valid = 4'b0001;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++; if (qr_ready !== 4'b0001 || nqr_push !== 1'b1 || nqr_id !== 2'd0) begin errors++; $display("FAIL tag_push%0d got=%h/%b/%0d", k, qr_ready, nqr_push, nqr_id); end
         tick();
      end
      checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL tag_count got=%0d exp=8", outstanding); end
      checks++; if (qr_ready !== 4'h0 || nqr_push !== 1'b0) begin errors++; $display("FAIL tag_stall got=%h/%b exp=0/0", qr_ready, nqr_push); end
      nresp_valid = 1'b1; nresp_found = 1'b1; nresp_result = 32'h100;
      #1;
      checks++; if (qr_ready !== 4'h0) begin errors++; $display("FAIL tag_no_bypass got=%h exp=0", qr_ready); end
      tick();
      nresp_valid = 1'b0;
      #1;
      checks++; if (qr_ready !== 4'b0001 || outstanding !== 4'd7) begin errors++; $display("FAIL tag_ninth got=%h/%0d exp=1/7", qr_ready, outstanding); end
      checks++; if (resp_valid !== 4'b0001 || resp_result !== 32'h100) begin errors++; $display("FAIL tag_resp0 got=%h/%h exp=1/100", resp_valid, resp_result); end
      tick();
      qr_valid = 4'h0;
      for (int k = 0; k < 8; k++) begin
         nresp_valid = 1'b1; nresp_result = 32'h200 + 32'(k);
         tick();
         checks++; if (resp_valid !== 4'b0001 || resp_result !== 32'h200 + 32'(k)) begin errors++; $display("FAIL tag_flush%0d got=%h/%h", k, resp_valid, resp_result); end
      end
      nresp_valid = 1'b0;
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL tag_empty got=%0d exp=0", outstanding); end
      tick();
   endtask

   task automatic test_routing();
      logic [3:0]  src [3];
      logic [1:0]  sid [3];
      logic        fnd [3];
      logic [31:0] res [3];
      src = '{4'b1000, 4'b0010, 4'b1000};
      sid = '{2'd3, 2'd1, 2'd3};
      fnd = '{1'b1, 1'b0, 1'b1};
      res = '{32'hA, 32'hB, 32'hC};
      for (int k = 0; k < 3; k++) begin
         qr_valid = src[k];
         #1;
         checks++; if (qr_ready !== src[k] || nqr_id !== sid[k] || nqr_addr !== 16'h2000 + 16'(sid[k]) || nqr_feature !== 64'hF000 + 64'(sid[k])) begin errors++; $display("FAIL route_issue%0d got=%h/%0d/%h", k, qr_ready, nqr_id, nqr_addr); end
         tick();
      end
      qr_valid = 4'h0;
      checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL route_outst got=%0d exp=3", outstanding); end
      for (int k = 0; k < 3; k++) begin
         nresp_valid = 1'b1; nresp_found = fnd[k]; nresp_result = res[k];
         if (k == 0) begin
            #1;
            checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL route_latency got=%h exp=0", resp_valid); end
         end
         tick();
         checks++; if (resp_valid !== src[k] || resp_found !== fnd[k] || resp_result !== res[k]) begin errors++; $display("FAIL route_resp%0d got=%h/%b/%h exp=%h/%b/%h", k, resp_valid, resp_found, resp_result, src[k], fnd[k], res[k]); end
      end
      nresp_valid = 1'b0;
      tick();
      checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL route_strobe got=%h exp=0", resp_valid); end
   endtask

   task automatic test_drain();
      qr_valid = 4'b0001;
      tick(); tick();
      qr_valid = 4'h0;
      checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL drain_setup got=%0d exp=2", outstanding); end
      drain = 1'b1;
      tick();
      wr_valid = 4'b0001; qr_valid = 4'b0001;
      #1;
      checks++; if (wr_ready !== 4'h0 || qr_ready !== 4'h0 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_block got=%h/%h/%b exp=0/0/0", wr_ready, qr_ready, drain_done); end
      nresp_valid = 1'b1; nresp_result = 32'h31;
      tick();
      checks++; if (resp_valid !== 4'b0001 || qr_ready !== 4'h0 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_resp1 got=%h/%h/%b exp=1/0/0", resp_valid, qr_ready, drain_done); end
      nresp_result = 32'h32;
      tick();
      nresp_valid = 1'b0;
      checks++; if (resp_valid !== 4'b0001 || outstanding !== 4'd0 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_resp2 got=%h/%0d/%b exp=1/0/0", resp_valid, outstanding, drain_done); end
      tick();
      checks++; if (drain_done !== 1'b1 || wr_ready !== 4'h0) begin errors++; $display("FAIL drain_done got=%b/%h exp=1/0", drain_done, wr_ready); end
      drain = 1'b0;
      tick();
      checks++; if (drain_done !== 1'b0 || wr_ready !== 4'b0001 || qr_ready !== 4'b0001) begin errors++; $display("FAIL drain_resume got=%b/%h/%h exp=0/1/1", drain_done, wr_ready, qr_ready); end
      tick();
      wr_valid = 4'h0; qr_valid = 4'h0;
      nresp_valid = 1'b1;
      tick();
      nresp_valid = 1'b0;
      drain = 1'b1;
      tick();
      checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drain_fast got=%b exp=1", drain_done); end
      drain = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      qr_valid = 4'b0100;
      tick();
      qr_valid = 4'b0001; nresp_valid = 1'b1; nresp_result = 32'h55;
      #1;
      checks++; if (qr_ready !== 4'b0001) begin errors++; $display("FAIL b2b_grant got=%h exp=1", qr_ready); end
      tick();
      qr_valid = 4'h0; nresp_result = 32'h66;
      checks++; if (outstanding !== 4'd1 || resp_valid !== 4'b0100 || resp_result !== 32'h55) begin errors++; $display("FAIL b2b_pushpop got=%0d/%h/%h exp=1/4/55", outstanding, resp_valid, resp_result); end
      tick();
      nresp_valid = 1'b0;
      checks++; if (outstanding !== 4'd0 || resp_valid !== 4'b0001 || resp_result !== 32'h66) begin errors++; $display("FAIL b2b_second got=%0d/%h/%h exp=0/1/66", outstanding, resp_valid, resp_result); end
      tick();
   endtask

   task automatic test_orphan();
      nresp_valid = 1'b1; nresp_result = 32'hDEAD;
      tick();
      nresp_valid = 1'b0;
      checks++; if (resp_valid !== 4'h0 || err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%h/%b exp=0/1", resp_valid, err_orphan); end
      tick(); tick();
      checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
      rst = 1'b0;
      #2;
      checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
      rst = 1'b1;
      tick();
      qr_valid = 4'b0010;
      tick();
      qr_valid = 4'h0;
      checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL midrst_setup got=%0d exp=1", outstanding); end
      rst = 1'b0;
      #2;
      checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL midrst_discard got=%0d exp=0", outstanding); end
      rst = 1'b1;
      tick();
      nresp_valid = 1'b1;
      tick();
      nresp_valid = 1'b0;
      checks++; if (resp_valid !== 4'h0 || err_orphan !== 1'b1) begin errors++; $display("FAIL midrst_stale got=%h/%b exp=0/1", resp_valid, err_orphan); end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_tag_limit();
      test_routing();
      test_drain();
      test_back_to_back();
      test_orphan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
